// File: rtl/pending_priority_encoder_pkg.sv
// Shared definitions for the pending priority encoder and its helpers.
//   PE_N_DEFAULT : default number of request lines
//   pe_width()   : index width derived from the number of request lines
//   pe_state_e   : output stage state (EMPTY = nothing presented, FULL = index presented)
package pe_pkg;

  localparam int PE_N_DEFAULT = 8;

  // Index width for n request lines; never narrower than one bit.
  function automatic int pe_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    PE_EMPTY = 1'b0,
    PE_FULL  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pending_priority_encoder_prio_sel.sv
// Combinational MSB-first find-first-set.
//   vec_i   : candidate vector (N bits)
//   idx_o   : index of the highest set bit (0 when nothing is set)
//   found_o : high when any bit of vec_i is set
module prio_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Ascending scan: the last set bit seen overwrites earlier ones, so the
  // highest index wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Pending-request priority encoder with a valid/ready output stage.
// Request strobes are collected into a pending register; the highest-index
// pending, unmasked request is presented as a binary index (and one-hot) and
// is retired from pending when the consumer accepts it.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_i      : request strobes, set pending bits
//   mask_i     : 1 = bit eligible for selection
//   clr_i      : synchronous flush of pending bits and output stage
//   ready_i    : consumer accepts the presented index
//   valid_o    : an event is being presented
//   idx_o      : binary index of the presented event
//   onehot_o   : one-hot form of idx_o, zero when valid_o is low
//   pending_o  : current pending register
//   overflow_o : one-cycle pulse, a request hit an already-pending bit
module pending_priority_encoder
  import pe_pkg::*;
#(
  parameter  int N = PE_N_DEFAULT,
  localparam int W = pe_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         clr_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic [N-1:0] pending_o,
  output logic         overflow_o
);

  pe_state_e    state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;

  logic         accept;
  logic [N-1:0] acc_mask;
  logic [N-1:0] cand;
  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic [N-1:0] sel_onehot;

  // Candidates come from the registered pending bits only, with the event
  // being retired this cycle removed so it is never re-selected.
  assign accept   = (state_q == PE_FULL) & ready_i;
  assign acc_mask = accept ? onehot_q : '0;
  assign cand     = pending_q & mask_i & ~acc_mask;

  prio_sel #(
    .N (N),
    .W (W)
  ) u_prio_sel (
    .vec_i   (cand),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel_idx == W'(gi));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    // A request on the bit being accepted re-sets it as a fresh event.
    pending_d  = (pending_q & ~acc_mask) | req_i;
    overflow_d = |(req_i & pending_q & ~acc_mask);

    if (clr_i) begin
      state_d    = PE_EMPTY;
      onehot_d   = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        PE_EMPTY: begin
          if (sel_found) begin
            state_d  = PE_FULL;
            idx_d    = sel_idx;
            onehot_d = sel_onehot;
          end
        end
        PE_FULL: begin
          // Without an accept the presented event is frozen, even if a
          // higher-priority bit arrives or its mask bit drops.
          if (accept) begin
            if (sel_found) begin
              idx_d    = sel_idx;
              onehot_d = sel_onehot;
            end else begin
              state_d  = PE_EMPTY;
              onehot_d = '0;
            end
          end
        end
        default: begin
          state_d  = PE_EMPTY;
          onehot_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PE_EMPTY;
      idx_q      <= '0;
      onehot_q   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = (state_q == PE_FULL);
  assign idx_o      = idx_q;
  assign onehot_o   = onehot_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
module tb_pending_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic [N-1:0] mask_i;
  logic         clr_i;
  logic         ready_i;
  logic         valid_o;
  logic [W-1:0] idx_o;
  logic [N-1:0] onehot_o;
  logic [N-1:0] pending_o;
  logic         overflow_o;

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .clr_i      (clr_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .idx_o      (idx_o),
    .onehot_o   (onehot_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  typedef struct {
    bit       valid;
    int       idx;
    bit [7:0] onehot;
    bit [7:0] pending;
    bit       ovf;
    int       cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: pending events as a bit array plus the presented index.
  bit   m_pend [N];
  bit   m_valid;
  int   m_idx;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = 0;
    m_valid = 0;
    m_idx   = 0;
  endtask

  // Advance the model by one clock edge with the given inputs and return the
  // outputs that should be visible after that edge.
  function automatic exp_t model_step(bit [7:0] req, bit [7:0] mask, bit clr, bit rdy);
    exp_t e;
    bit   accept;
    bit   ovf;
    bit   cand [N];
    int   best;
    accept = m_valid && rdy;
    ovf    = 0;
    if (clr) begin
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      m_valid = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        bit taken;
        taken   = accept && (k == m_idx);
        if (req[k] && m_pend[k] && !taken) ovf = 1;
        cand[k] = m_pend[k] && mask[k] && !taken;
        m_pend[k] = (m_pend[k] && !taken) || req[k];
      end
      if (!m_valid || accept) begin
        best = -1;
        for (int k = N - 1; k >= 0; k--) begin
          if (cand[k]) begin
            best = k;
            break;
          end
        end
        if (best >= 0) begin
          m_valid = 1;
          m_idx   = best;
        end else begin
          m_valid = 0;
        end
      end
    end
    e.valid  = m_valid;
    e.idx    = m_idx;
    e.onehot = m_valid ? 8'(1 << m_idx) : 8'h00;
    for (int k = 0; k < N; k++) e.pending[k] = m_pend[k];
    e.ovf    = ovf;
    return e;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the expectation.
  task automatic step(input bit [7:0] req, input bit [7:0] mask, input bit clr, input bit rdy);
    exp_t e;
    @(negedge clk);
    req_i   = req;
    mask_i  = mask;
    clr_i   = clr;
    ready_i = rdy;
    e = model_step(req, mask, clr, rdy);
    cyc++;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("valid c%0d", e.cyc), int'(valid_o), int'(e.valid));
        chk($sformatf("idx c%0d", e.cyc), int'(idx_o), e.idx);
        chk($sformatf("onehot c%0d", e.cyc), int'(onehot_o), int'(e.onehot));
        chk($sformatf("pending c%0d", e.cyc), int'(pending_o), int'(e.pending));
        chk($sformatf("overflow c%0d", e.cyc), int'(overflow_o), int'(e.ovf));
        $display("cycle %0d: valid=%0d idx=%0d onehot=%02h pending=%02h ovf=%0d",
                 e.cyc, valid_o, idx_o, onehot_o, pending_o, overflow_o);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " valid"}, int'(valid_o), 0);
    chk({tag, " idx"}, int'(idx_o), 0);
    chk({tag, " onehot"}, int'(onehot_o), 0);
    chk({tag, " pending"}, int'(pending_o), 0);
    chk({tag, " overflow"}, int'(overflow_o), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req_i   = '0;
    mask_i  = '0;
    clr_i   = 1'b0;
    ready_i = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single event held until accepted.
    step(8'h08, 8'hFF, 0, 0);
    repeat (4) step(8'h00, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 1);
    repeat (2) step(8'h00, 8'hFF, 0, 0);

    // Priority drain 7, 4, 0 back to back.
    step(8'h91, 8'hFF, 0, 1);
    repeat (5) step(8'h00, 8'hFF, 0, 1);

    // Hold stability while a higher-priority bit arrives.
    step(8'h04, 8'hFF, 0, 0);
    repeat (2) step(8'h00, 8'hFF, 0, 0);
    step(8'h80, 8'hFF, 0, 0);
    repeat (2) step(8'h00, 8'hFF, 0, 0);
    repeat (3) step(8'h00, 8'hFF, 0, 1);

    // Overflow on a non-accepted bit; same-cycle re-set on an accepted bit.
    step(8'h20, 8'hFF, 0, 0);
    repeat (2) step(8'h00, 8'hFF, 0, 0);
    step(8'h20, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    step(8'h20, 8'hFF, 0, 1);
    repeat (3) step(8'h00, 8'hFF, 0, 1);

    // Mask then flush.
    step(8'h06, 8'h00, 0, 0);
    repeat (3) step(8'h00, 8'h00, 0, 0);
    repeat (2) step(8'h00, 8'h02, 0, 0);
    step(8'h00, 8'h02, 1, 0);
    repeat (2) step(8'h00, 8'hFF, 0, 1);

    // Mid-operation asynchronous reset with pending = A5.
    step(8'hA5, 8'h00, 0, 0);
    step(8'h00, 8'h00, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    req_i = '0; mask_i = 8'hFF; clr_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(8'h00, 8'hFF, 0, 0);

    // All-ones drain.
    step(8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    repeat (10) step(8'h00, 8'hFF, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] r, m;
      bit c, rd;
      r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      m  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      c  = ($urandom_range(0, 60) == 0);
      rd = ($urandom_range(0, 2) != 0);
      step(r, m, c, rd);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
